// File: rtl/axi_llc_arcane_pkg.sv
// Shared types and constants for the ARCANE descriptor mux.
//   arcane_mux_state_e : lock-mode FSM states of the descriptor mux
//   ArcMaxOutstanding  : default bound on in-flight ARCANE descriptors
package axi_llc_arcane_pkg;

    localparam int unsigned ArcMaxOutstanding = 8;

    typedef enum logic [1:0] {
        StNormal = 2'd0,
        StToArc  = 2'd1,
        StArcane = 2'd2,
        StToNorm = 2'd3
    } arcane_mux_state_e;

endpackage

// File: rtl/axi_llc_arcane_desc_reg.sv
// Single-entry valid/ready register carrying a descriptor plus a one-bit tag.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   in_desc_i/tag_i   : descriptor and tag to store
//   in_valid_i        : push request (upstream qualifies it with in_ready_o)
//   in_ready_o        : entry free, or being drained this cycle
//   out_desc_o/tag_o  : stored descriptor and tag
//   out_valid_o       : entry occupied
//   out_ready_i       : downstream accepts the entry
module axi_llc_arcane_desc_reg #(
    parameter type desc_t = logic
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  desc_t in_desc_i,
    input  logic  in_tag_i,
    input  logic  in_valid_i,
    output logic  in_ready_o,
    output desc_t out_desc_o,
    output logic  out_tag_o,
    output logic  out_valid_o,
    input  logic  out_ready_i
);

    logic  full_q, full_d;
    logic  tag_q, tag_d;
    desc_t desc_q, desc_d;

    always_comb begin
        in_ready_o = !full_q || out_ready_i;
        full_d     = full_q;
        tag_d      = tag_q;
        desc_d     = desc_q;
        if (in_valid_i && in_ready_o) begin
            full_d = 1'b1;
            tag_d  = in_tag_i;
            desc_d = in_desc_i;
        end else if (out_ready_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            tag_q  <= 1'b0;
            desc_q <= '0;
        end else begin
            full_q <= full_d;
            tag_q  <= tag_d;
            desc_q <= desc_d;
        end
    end

    assign out_desc_o  = desc_q;
    assign out_tag_o   = tag_q;
    assign out_valid_o = full_q;

endmodule

// File: rtl/axi_llc_arcane_desc_mux.sv
// Merges normal-path and ARCANE DMA descriptors towards the hit/miss unit.
// ARCANE descriptors pass only while the LLC is locked, normal ones only while
// unlocked; mode changes wait for the output register to empty (and, leaving
// ARCANE, for all in-flight ARCANE descriptors to complete).
// Ports:
//   clk_i, rst_i                    : clock, synchronous active-high reset
//   lock_i                          : LLC locked for ARCANE
//   norm_desc/valid_i, norm_ready_o : normal-path descriptor input
//   arc_desc/valid_i, arc_ready_o   : ARCANE descriptor input
//   desc_o, desc_valid_o, desc_ready_i : descriptor output to hit/miss unit
//   arc_done_i                      : pulse, one ARCANE descriptor completed
//   mode_arcane_o, drained_o        : mode status for the lock FSM
//   arc_outstanding_o               : in-flight ARCANE count
//   err_o                           : sticky protocol error
module axi_llc_arcane_desc_mux
    import axi_llc_arcane_pkg::*;
#(
    parameter type         desc_t         = logic,
    parameter int unsigned MaxOutstanding = ArcMaxOutstanding,
    parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                lock_i,
    input  desc_t               norm_desc_i,
    input  logic                norm_valid_i,
    output logic                norm_ready_o,
    input  desc_t               arc_desc_i,
    input  logic                arc_valid_i,
    output logic                arc_ready_o,
    output desc_t               desc_o,
    output logic                desc_valid_o,
    input  logic                desc_ready_i,
    input  logic                arc_done_i,
    output logic                mode_arcane_o,
    output logic                drained_o,
    output logic [CntWidth-1:0] arc_outstanding_o,
    output logic                err_o
);

    arcane_mux_state_e   state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                err_q, err_d;

    logic        reg_in_ready, reg_full, reg_tag, reg_push, reg_in_tag;
    desc_t       reg_in_desc;
    logic        full_arc, arc_room, cnt_inc, cnt_dec;
    logic [31:0] occupancy;

    axi_llc_arcane_desc_reg #(
        .desc_t(desc_t)
    ) u_desc_reg (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_desc_i  (reg_in_desc),
        .in_tag_i   (reg_in_tag),
        .in_valid_i (reg_push),
        .in_ready_o (reg_in_ready),
        .out_desc_o (desc_o),
        .out_tag_o  (reg_tag),
        .out_valid_o(reg_full),
        .out_ready_i(desc_ready_i)
    );

    // Source gating and input selection.
    always_comb begin
        full_arc  = reg_full && reg_tag;
        // An ARCANE entry still in the register counts against the limit so
        // the counter cannot exceed MaxOutstanding once it is emitted.
        occupancy = 32'(cnt_q) + 32'(full_arc);
        arc_room  = occupancy < MaxOutstanding;

        norm_ready_o = (state_q == StNormal) && reg_in_ready;
        arc_ready_o  = (state_q == StArcane) && reg_in_ready && arc_room;

        reg_in_tag  = (state_q == StArcane);
        reg_in_desc = reg_in_tag ? arc_desc_i : norm_desc_i;
        reg_push    = (norm_valid_i && norm_ready_o) || (arc_valid_i && arc_ready_o);
    end

    // Outstanding counter and sticky error.
    always_comb begin
        cnt_inc = desc_valid_o && desc_ready_i && reg_tag;
        // A completion with nothing outstanding is an error, not a wrap.
        cnt_dec = arc_done_i && (cnt_q != '0);
        cnt_d   = cnt_q;
        if (cnt_inc && !cnt_dec) begin
            cnt_d = cnt_q + CntWidth'(1);
        end else if (!cnt_inc && cnt_dec) begin
            cnt_d = cnt_q - CntWidth'(1);
        end

        err_d = err_q
              || (arc_done_i && (cnt_q == '0))
              || (arc_valid_i && (state_q == StNormal));
    end

    // Mode FSM.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StNormal: begin
                if (lock_i) state_d = StToArc;
            end
            StToArc: begin
                if (!lock_i)        state_d = StNormal;
                else if (!reg_full) state_d = StArcane;
            end
            StArcane: begin
                if (!lock_i) state_d = StToNorm;
            end
            StToNorm: begin
                if (lock_i) begin
                    state_d = StArcane;
                end else if (!reg_full && (cnt_q == '0) && !arc_done_i) begin
                    state_d = StNormal;
                end
            end
            default: state_d = StNormal;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StNormal;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign desc_valid_o      = reg_full;
    assign mode_arcane_o     = (state_q == StArcane);
    assign drained_o         = (state_q == StNormal) && !reg_full && (cnt_q == '0);
    assign arc_outstanding_o = cnt_q;
    assign err_o             = err_q;

endmodule

// File: tb/tb_axi_llc_arcane_desc_mux.sv
module tb_axi_llc_arcane_desc_mux;

    localparam int unsigned MaxOut = 8;
    localparam int unsigned CW     = $clog2(MaxOut + 1);

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  id;
    } desc_t;

    typedef struct {
        desc_t d;
        logic  arc;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          lock_i;
    desc_t         norm_desc_i, arc_desc_i, desc_o;
    logic          norm_valid_i, norm_ready_o;
    logic          arc_valid_i, arc_ready_o;
    logic          desc_valid_o, desc_ready_i;
    logic          arc_done_i, mode_arcane_o, drained_o, err_o;
    logic [CW-1:0] arc_outstanding_o;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cnt_model = 0;
    bit   mon_en = 0;
    exp_t exp_q[$];

    always #5 clk_i = ~clk_i;

    axi_llc_arcane_desc_mux #(
        .desc_t        (desc_t),
        .MaxOutstanding(MaxOut)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .lock_i           (lock_i),
        .norm_desc_i      (norm_desc_i),
        .norm_valid_i     (norm_valid_i),
        .norm_ready_o     (norm_ready_o),
        .arc_desc_i       (arc_desc_i),
        .arc_valid_i      (arc_valid_i),
        .arc_ready_o      (arc_ready_o),
        .desc_o           (desc_o),
        .desc_valid_o     (desc_valid_o),
        .desc_ready_i     (desc_ready_i),
        .arc_done_i       (arc_done_i),
        .mode_arcane_o    (mode_arcane_o),
        .drained_o        (drained_o),
        .arc_outstanding_o(arc_outstanding_o),
        .err_o            (err_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: samples on the falling edge, i.e. the handshakes that
    // the next rising edge will commit.
    always @(negedge clk_i) begin
        exp_t e;
        bit   dec;
        if (mon_en) begin
            check("outstanding", 64'(arc_outstanding_o), 64'(cnt_model));
            check("arc_ready_outside_arcane", 64'(arc_ready_o && !mode_arcane_o), 64'(0));
            check("norm_ready_in_arcane", 64'(norm_ready_o && mode_arcane_o), 64'(0));
            if (rst_i) begin
                exp_q.delete();
                cnt_model = 0;
            end else begin
                dec = arc_done_i && (cnt_model > 0);
                if (desc_valid_o && desc_ready_i) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 64'(desc_o), 64'(0) - 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("desc_data", 64'(desc_o), 64'(e.d));
                        if (e.arc) cnt_model++;
                    end
                end
                if (dec) cnt_model--;
                if (norm_valid_i && norm_ready_o) exp_q.push_back('{d: norm_desc_i, arc: 1'b0});
                if (arc_valid_i && arc_ready_o)   exp_q.push_back('{d: arc_desc_i, arc: 1'b1});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        step();
        rst_i = 1'b1;
        at_neg();
        step();
        rst_i = 1'b0;
    endtask

    // Offer one descriptor and hold it until accepted (bounded).
    task automatic issue(input logic arc, input logic [31:0] addr);
        bit ok = 0;
        step();
        if (arc) begin
            arc_desc_i  = '{addr: addr, id: 4'($urandom)};
            arc_valid_i = 1'b1;
        end else begin
            norm_desc_i  = '{addr: addr, id: 4'($urandom)};
            norm_valid_i = 1'b1;
        end
        for (int i = 0; i < 30; i++) begin
            at_neg();
            if (arc ? arc_ready_o : norm_ready_o) begin
                ok = 1;
                break;
            end
        end
        check("issue_accepted", 64'(ok), 64'(1));
        step();
        arc_valid_i  = 1'b0;
        norm_valid_i = 1'b0;
    endtask

    task automatic wait_mode(input logic want, input string name);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            at_neg();
            if (mode_arcane_o == want) begin
                ok = 1;
                break;
            end
        end
        check(name, 64'(ok), 64'(1));
    endtask

    task automatic pulse_done();
        step();
        arc_done_i = 1'b1;
        at_neg();
        step();
        arc_done_i = 1'b0;
    endtask

    initial begin
        int acc;
        bit ok;
        rst_i = 1'b1; lock_i = 1'b0; desc_ready_i = 1'b0; arc_done_i = 1'b0;
        norm_valid_i = 1'b0; arc_valid_i = 1'b0; norm_desc_i = '0; arc_desc_i = '0;
        step();
        step();
        rst_i = 1'b0;
        mon_en = 1;

        // Reset values.
        at_neg();
        check("rst_desc_valid", 64'(desc_valid_o), 64'(0));
        check("rst_desc", 64'(desc_o), 64'(0));
        check("rst_mode", 64'(mode_arcane_o), 64'(0));
        check("rst_drained", 64'(drained_o), 64'(1));
        check("rst_err", 64'(err_o), 64'(0));

        // Normal pass-through, back to back, one-cycle latency.
        desc_ready_i = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            step();
            if (i < 4) begin
                norm_valid_i = 1'b1;
                norm_desc_i  = '{addr: 32'(i * 32'h40), id: 4'(i)};
            end else begin
                norm_valid_i = 1'b0;
            end
            at_neg();
            check("pt_arc_ready", 64'(arc_ready_o), 64'(0));
            if (i < 4) check("pt_norm_ready", 64'(norm_ready_o), 64'(1));
            check("pt_valid", 64'(desc_valid_o), 64'(i > 0));
            if (i > 0) check("pt_addr", 64'(desc_o.addr), 64'((i - 1) * 32'h40));
        end
        check("pt_err", 64'(err_o), 64'(0));

        // Mode entry with a stalled full register.
        step();
        desc_ready_i = 1'b0;
        issue(1'b0, 32'h100);
        lock_i = 1'b1;
        at_neg();
        step();
        for (int i = 0; i < 3; i++) begin
            at_neg();
            check("toarc_valid_held", 64'(desc_valid_o), 64'(1));
            check("toarc_addr_held", 64'(desc_o.addr), 64'(32'h100));
            check("toarc_norm_ready", 64'(norm_ready_o), 64'(0));
            check("toarc_arc_ready", 64'(arc_ready_o), 64'(0));
            check("toarc_mode", 64'(mode_arcane_o), 64'(0));
            step();
        end
        desc_ready_i = 1'b1;
        wait_mode(1'b1, "enter_arcane");
        check("arcane_arc_ready", 64'(arc_ready_o), 64'(1));

        // Saturation: offer 10, only MaxOut may be taken without completions.
        acc = 0;
        step();
        arc_valid_i = 1'b1;
        arc_desc_i  = '{addr: 32'h1000, id: 4'h0};
        for (int i = 0; i < 16; i++) begin
            at_neg();
            ok = arc_ready_o;
            if (ok) acc++;
            step();
            if (ok && acc < 10) arc_desc_i = '{addr: 32'h1000 + 32'(acc) * 32'h40, id: 4'(acc)};
        end
        at_neg();
        check("sat_accepted", 64'(acc), 64'(MaxOut));
        check("sat_count", 64'(arc_outstanding_o), 64'(MaxOut));
        check("sat_arc_ready", 64'(arc_ready_o), 64'(0));
        pulse_done();
        at_neg();
        check("sat_ready_after_done", 64'(arc_ready_o), 64'(1));
        if (arc_ready_o) acc++;
        step();
        arc_valid_i = 1'b0;
        check("sat_ninth", 64'(acc), 64'(MaxOut + 1));
        at_neg();
        step();
        at_neg();
        check("sat_count_again", 64'(arc_outstanding_o), 64'(MaxOut));

        // Simultaneous increment and decrement.
        for (int i = 0; i < 6; i++) pulse_done();
        at_neg();
        check("cnt_two", 64'(arc_outstanding_o), 64'(2));
        step();
        arc_valid_i = 1'b1;
        arc_desc_i  = '{addr: 32'h2000, id: 4'h5};
        at_neg();
        check("simul_accept", 64'(arc_ready_o), 64'(1));
        step();
        arc_valid_i = 1'b0;
        arc_done_i  = 1'b1;
        at_neg();
        check("simul_out_valid", 64'(desc_valid_o), 64'(1));
        step();
        arc_done_i = 1'b0;
        at_neg();
        check("simul_count", 64'(arc_outstanding_o), 64'(2));

        // Drain back to normal from three outstanding.
        issue(1'b1, 32'h3000);
        step();
        at_neg();
        check("cnt_three", 64'(arc_outstanding_o), 64'(3));
        step();
        lock_i       = 1'b0;
        norm_valid_i = 1'b1;
        norm_desc_i  = '{addr: 32'h4000, id: 4'h1};
        at_neg();
        step();
        at_neg();
        check("tonorm_mode", 64'(mode_arcane_o), 64'(0));
        check("tonorm_norm_ready", 64'(norm_ready_o), 64'(0));
        check("tonorm_drained", 64'(drained_o), 64'(0));
        step();
        norm_valid_i = 1'b0;
        pulse_done();
        step();
        pulse_done();
        step();
        pulse_done();
        ok = 0;
        for (int i = 0; i < 6; i++) begin
            at_neg();
            if (drained_o) begin
                ok = 1;
                break;
            end
        end
        check("drained_reached", 64'(ok), 64'(1));
        check("drained_count", 64'(arc_outstanding_o), 64'(0));

        // Errors.
        step();
        arc_valid_i = 1'b1;
        arc_desc_i  = '{addr: 32'h5000, id: 4'h2};
        at_neg();
        check("err_arc_ready", 64'(arc_ready_o), 64'(0));
        check("err_before", 64'(err_o), 64'(0));
        step();
        arc_valid_i = 1'b0;
        at_neg();
        check("err_unlocked_dma", 64'(err_o), 64'(1));
        check("err_no_output", 64'(desc_valid_o), 64'(0));
        do_reset();
        at_neg();
        check("err_cleared", 64'(err_o), 64'(0));
        step();
        arc_done_i = 1'b1;
        at_neg();
        step();
        arc_done_i = 1'b0;
        at_neg();
        check("err_done_at_zero", 64'(err_o), 64'(1));
        check("err_count_no_wrap", 64'(arc_outstanding_o), 64'(0));
        do_reset();

        // Reset mid-operation.
        step();
        lock_i = 1'b1;
        desc_ready_i = 1'b1;
        wait_mode(1'b1, "rst_test_arcane");
        for (int i = 0; i < 5; i++) issue(1'b1, 32'h6000 + 32'(i) * 32'h40);
        step();
        at_neg();
        check("cnt_five", 64'(arc_outstanding_o), 64'(5));
        step();
        desc_ready_i = 1'b0;
        issue(1'b1, 32'h7000);
        at_neg();
        check("pre_rst_full", 64'(desc_valid_o), 64'(1));
        step();
        rst_i  = 1'b1;
        lock_i = 1'b0;
        at_neg();
        step();
        rst_i = 1'b0;
        at_neg();
        check("midrst_valid", 64'(desc_valid_o), 64'(0));
        check("midrst_count", 64'(arc_outstanding_o), 64'(0));
        check("midrst_mode", 64'(mode_arcane_o), 64'(0));
        check("midrst_drained", 64'(drained_o), 64'(1));

        // Randomised traffic against the scoreboard.
        for (int c = 0; c < 1500; c++) begin
            step();
            desc_ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) lock_i = !lock_i;
            norm_valid_i = 1'($urandom_range(0, 1));
            norm_desc_i  = '{addr: $urandom, id: 4'($urandom)};
            arc_valid_i  = mode_arcane_o && ($urandom_range(0, 1) == 1);
            arc_desc_i   = '{addr: $urandom, id: 4'($urandom)};
            arc_done_i   = (cnt_model > 0) && ($urandom_range(0, 2) == 0);
        end
        step();
        lock_i = 1'b0; norm_valid_i = 1'b0; arc_valid_i = 1'b0; desc_ready_i = 1'b1;
        arc_done_i = 1'b0;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            arc_done_i = (cnt_model > 0);
            at_neg();
            if (drained_o) begin
                ok = 1;
                break;
            end
        end
        step();
        arc_done_i = 1'b0;
        check("rand_drained", 64'(ok), 64'(1));
        check("rand_err", 64'(err_o), 64'(0));
        check("rand_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
